ninjakun_irq_timer_bank: RTL

//  Parametrised interrupt generator for the Z80 CPUs: NCH independent channels, each raising a level IRQ
//  on the VBLANK rising edge, on a programmable periodic timer, or on a timer resynchronised to VBLANK.

---
 rtl/ninjakun_irq_pkg.sv | 16 +
 rtl/ninjakun_irq_timer_bank_if.sv | 25 ++
 rtl/ninjakun_irq_chan.sv | 87 ++++++++
 rtl/ninjakun_irq_timer_bank.sv | 59 +++++
 4 files changed

// File: rtl/ninjakun_irq_pkg.sv
// Shared constants for the Ninjakun IRQ timer bank: channel mode encodings and the default timer period.
package ninjakun_irq_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_VBL  = 2'b01;
  localparam logic [1:0] MODE_TMR  = 2'b10;
  localparam logic [1:0] MODE_SYNC = 2'b11;

  // 1/240 s at the 3 MHz tick rate
  localparam int unsigned DEF_PERIOD = 12500;

  function automatic logic mode_has_timer(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/ninjakun_irq_timer_bank_if.sv
// Bus bundle between the video/CPU side and the IRQ timer bank; packed per-channel fields.
interface ninjakun_irq_timer_bank_if #(
  parameter int NCH  = 2,
  parameter int CNTW = 14
);
  logic                 ce;
  logic                 vblk;
  logic [2*NCH-1:0]     mode;
  logic [CNTW*NCH-1:0]  period;
  logic [CNTW*NCH-1:0]  phase;
  logic [NCH-1:0]       irq_ack;
  logic [NCH-1:0]       ovf_clr;
  logic [NCH-1:0]       irq;
  logic [NCH-1:0]       ovf;

  modport master (
    output ce, vblk, mode, period, phase, irq_ack, ovf_clr,
    input  irq, ovf
  );

  modport slave (
    input  ce, vblk, mode, period, phase, irq_ack, ovf_clr,
    output irq, ovf
  );
endinterface

// File: rtl/ninjakun_irq_chan.sv
// One IRQ channel: tick counter, timer/VBLANK event selection, ack edge detect, IRQ and sticky overrun flags.
module ninjakun_irq_chan
  import ninjakun_irq_pkg::*;
#(
  parameter int CNTW = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            vbe,
  input  logic [1:0]      mode,
  input  logic [CNTW-1:0] period,
  input  logic [CNTW-1:0] phase,
  input  logic            irq_ack,
  input  logic            ovf_clr,
  output logic            irq,
  output logic            ovf
);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            irq_q, irq_d;
  logic            ovf_q, ovf_d;
  logic            pack_q, pack_d;
  logic            tmr_en;
  logic            tev;
  logic            ev;
  logic            acke;
  logic [CNTW-1:0] period_m1;

  always_comb begin
    tmr_en    = mode_has_timer(mode) && (period != '0);
    period_m1 = tmr_en ? (period - 1'b1) : '0;
    tev       = ce && tmr_en && (cnt_q == phase);
    acke      = irq_ack && !pack_q;
    pack_d    = irq_ack;

    unique case (mode)
      MODE_VBL:  ev = vbe;
      MODE_TMR:  ev = tev;
      MODE_SYNC: ev = tev || vbe;
      default:   ev = 1'b0;
    endcase

    // A shrunken PERIOD below cnt is not guarded: cnt runs on and wraps at 2^CNTW.
    cnt_d = cnt_q;
    if ((mode == MODE_SYNC) && vbe) begin
      cnt_d = '0;
    end else if (!tmr_en) begin
      cnt_d = '0;
    end else if (ce) begin
      cnt_d = (cnt_q == period_m1) ? '0 : cnt_q + 1'b1;
    end

    irq_d = irq_q;
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    // Set beats ack; a second event on a pending request is a missed interrupt.
    if (ev && irq_q) begin
      irq_d = 1'b1;
      ovf_d = 1'b1;
    end else if (ev) begin
      irq_d = 1'b1;
    end else if (acke) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      irq_q  <= 1'b0;
      ovf_q  <= 1'b0;
      pack_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      irq_q  <= irq_d;
      ovf_q  <= ovf_d;
      pack_q <= pack_d;
    end
  end

  assign irq = irq_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/ninjakun_irq_timer_bank.sv
// Z80 interrupt generator bank: shared VBLANK edge detect feeding NCH independent timer/VBLANK IRQ channels.
module ninjakun_irq_timer_bank
  import ninjakun_irq_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int CNTW = 14
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ninjakun_irq_timer_bank_if.slave    bus
);

  logic           pvblk_q, pvblk_d;
  logic           armed_q, armed_d;
  logic           vbe;
  logic           ce_g;
  logic [NCH-1:0] irq_w;
  logic [NCH-1:0] ovf_w;

  // Events are suppressed on the first CLK after reset release, even if VBLK is already high.
  always_comb begin
    pvblk_d = bus.vblk;
    armed_d = 1'b1;
    vbe     = armed_q && bus.vblk && !pvblk_q;
    ce_g    = armed_q && bus.ce;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pvblk_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      pvblk_q <= pvblk_d;
      armed_q <= armed_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    ninjakun_irq_chan #(
      .CNTW (CNTW)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .ce      (ce_g),
      .vbe     (vbe),
      .mode    (bus.mode[2*i +: 2]),
      .period  (bus.period[CNTW*i +: CNTW]),
      .phase   (bus.phase[CNTW*i +: CNTW]),
      .irq_ack (bus.irq_ack[i]),
      .ovf_clr (bus.ovf_clr[i]),
      .irq     (irq_w[i]),
      .ovf     (ovf_w[i])
    );
  end

  assign bus.irq = irq_w;
  assign bus.ovf = ovf_w;

endmodule
